// File: rtl/single_port_sram_ctrl_pkg.sv
// single_port_sram_ctrl_pkg: shared state encoding for the SRAM controller FSM.
package single_port_sram_ctrl_pkg;
    typedef enum logic [2:0] {IDLE = 3'd0, WR = 3'd1, RD_A = 3'd2, RD_D = 3'd3, RSP = 3'd4} state_e;
endpackage

// File: rtl/single_port_sram.sv
// single_port_sram: word SRAM with registered read, driving the shared bus only when output-enabled.
module single_port_sram #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] address,
    inout  wire  [WIDTH-1:0]      data,
    input  logic                  chip_select,
    input  logic                  write_enable,
    input  logic                  output_enable
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_q;
    always_ff @(posedge clk) begin
        if (chip_select && write_enable) mem_q[address] <= data;
        if (chip_select && !write_enable) rd_q <= mem_q[address];
    end
    assign data = (chip_select && output_enable && !write_enable) ? rd_q : 'z;
endmodule

// File: rtl/single_port_sram_ctrl.sv
// single_port_sram_ctrl: turns a valid/ready request stream into SRAM cs/we/oe sequencing
// and returns read data as a held, back-pressured response; one request in flight.
module single_port_sram_ctrl
    import single_port_sram_ctrl_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0]      req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_rdata,
    output logic [ADDR_WIDTH-1:0] sram_address,
    inout  wire  [WIDTH-1:0]      sram_data,
    output logic                  sram_cs,
    output logic                  sram_we,
    output logic                  sram_oe
);
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]      wdata_q, wdata_d, rdata_q, rdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        rsp_valid_d = rsp_valid_q;
        case (state_q)
            IDLE: if (req_valid) begin
                addr_d  = req_addr;
                wdata_d = req_wdata;
                state_d = req_write ? WR : RD_A;
            end
            WR:   state_d = IDLE;
            RD_A: state_d = RD_D;
            RD_D: begin
                rdata_d     = sram_data;
                rsp_valid_d = 1'b1;
                state_d     = RSP;
            end
            RSP:  if (rsp_ready) begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    // SRAM side is decoded purely from registered state so no request input reaches the pins
    assign req_ready    = (state_q == IDLE);
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rdata_q;
    assign sram_address = addr_q;
    assign sram_cs      = (state_q == WR) || (state_q == RD_A) || (state_q == RD_D);
    assign sram_we      = (state_q == WR);
    assign sram_oe      = (state_q == RD_D);
    assign sram_data    = (state_q == WR) ? wdata_q : 'z;
endmodule

// File: tb/tb_single_port_sram_ctrl.sv
// tb_single_port_sram_ctrl: controller plus SRAM checked against an array model through a response scoreboard.
module tb_single_port_sram_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b1;
    logic [3:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready, rsp_valid, sram_cs, sram_we, sram_oe;
    logic [31:0] rsp_rdata;
    logic [3:0]  sram_address;
    wire  [31:0] sram_data;
    int          total = 0, bad = 0;
    logic [31:0] mem_m [16];
    logic [31:0] exp_q [$];
    logic        seen = 1'b0;
    logic [31:0] held;

    single_port_sram_ctrl #(.WIDTH(32), .DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .sram_address(sram_address), .sram_data(sram_data),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_oe(sram_oe)
    );
    single_port_sram #(.WIDTH(32), .DEPTH(16)) sram (
        .clk(clk), .address(sram_address), .data(sram_data),
        .chip_select(sram_cs), .write_enable(sram_we), .output_enable(sram_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: pops on each new response, then requires the data to hold while valid
    always @(negedge clk) begin
        if (!rsp_valid) seen = 1'b0;
        else if (!seen) begin
            seen = 1'b1;
            if (exp_q.size() == 0) begin
                held = rsp_rdata;
                chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                held = exp_q.pop_front();
                chk("rsp_data", rsp_rdata, held);
            end
        end else chk("rsp_hold", rsp_rdata, held);
    end

    always @(negedge clk) begin
        if (sram_we || sram_oe) chk("bus_known", 32'(!$isunknown(sram_data)), 32'd1);
        else chk("bus_z", 32'(sram_data === 32'hzzzzzzzz), 32'd1);
        if (sram_oe) chk("oe_we_excl", 32'(sram_we), 32'd0);
    end

    // Called at a negedge; returns at the negedge after the accept edge with req_valid dropped
    task automatic issue(input logic w, input logic [3:0] a, input logic [31:0] d, input logic rnd);
        int n = 0;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        while (!req_ready && n < 200) begin
            if (rnd) rsp_ready = 1'($urandom_range(0, 1));
            @(negedge clk); n++;
        end
        if (!req_ready) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        if (w) mem_m[a] = d;
        else exp_q.push_back(mem_m[a]);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        rsp_ready = 1'b1;
        while (!(exp_q.size() == 0 && req_ready && !rsp_valid) && n < 100) begin
            @(negedge clk); n++;
        end
        chk("drain", 32'(exp_q.size() == 0 && req_ready && !rsp_valid), 32'd1);
    endtask

    initial begin
        #1;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_ctl", {29'd0, sram_cs, sram_we, sram_oe}, 32'd0);
        chk("rst_addr", 32'(sram_address), 32'd0);
        chk("rst_bus", 32'(sram_data === 32'hzzzzzzzz), 32'd1);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        // write then read with latency check
        issue(1'b1, 4'd3, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        issue(1'b0, 4'd3, 32'h0, 1'b0);
        chk("lat_e0", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("lat_e1", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("lat_e2", 32'(rsp_valid), 32'd1);
        chk("lat_data", rsp_rdata, 32'hDEADBEEF);
        wait_done();
        // back-to-back writes with req_valid held high
        req_valid = 1'b1; req_write = 1'b1;
        for (int i = 0; i < 16; i++) begin
            req_addr = 4'(i);
            req_wdata = 32'h11111111 * 32'((i == 0) ? 1 : i);
            chk("b2b_ready1", 32'(req_ready), 32'd1);
            @(posedge clk);
            mem_m[i] = req_wdata;
            @(negedge clk);
            chk("b2b_ready0", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        issue(1'b0, 4'd15, 32'h0, 1'b0);
        wait_done();
        issue(1'b0, 4'd0, 32'h0, 1'b0);
        wait_done();
        chk("model_15", mem_m[15], 32'hFFFFFFFF);
        chk("model_0", mem_m[0], 32'h11111111);
        // back-pressure on read @7
        rsp_ready = 1'b0;
        issue(1'b0, 4'd7, 32'h0, 1'b0);
        @(negedge clk); @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_ready", 32'(req_ready), 32'd0);
            chk("bp_data", rsp_rdata, mem_m[7]);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 32'(rsp_valid), 32'd0);
        chk("bp_release_ready", 32'(req_ready), 32'd1);
        wait_done();
        // random request mix with random back-pressure
        for (int i = 0; i < 500; i++) begin
            rsp_ready = 1'($urandom_range(0, 1));
            issue(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, 1'b1);
        end
        wait_done();
        // reset while the SRAM is driving the bus
        issue(1'b0, 4'd5, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        chk("pre_rst_oe", 32'(sram_oe), 32'd1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_ctl", {29'd0, sram_cs, sram_we, sram_oe}, 32'd0);
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_bus", 32'(sram_data === 32'hzzzzzzzz), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(1'b0, 4'd5, 32'h0, 1'b0);
        wait_done();
        issue(1'b0, 4'd3, 32'h0, 1'b0);
        wait_done();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
